// File: rtl/fetch_npc_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC opcodes, FSM states,
// and the branch-offset helper.
package fetch_npc_unit_pkg;

    localparam logic [3:0] NPC_PLUS4       = 4'd0;
    localparam logic [3:0] NPC_JUMP        = 4'd1;
    localparam logic [3:0] NPC_JUMPR       = 4'd2;
    localparam logic [3:0] NPC_BRANCH_BEQ  = 4'd3;
    localparam logic [3:0] NPC_BRANCH_BNE  = 4'd4;
    localparam logic [3:0] NPC_BRANCH_BLEZ = 4'd5;
    localparam logic [3:0] NPC_BRANCH_BGTZ = 4'd6;
    localparam logic [3:0] NPC_BRANCH_BLTZ = 4'd7;
    localparam logic [3:0] NPC_BRANCH_BGEZ = 4'd8;
    localparam logic [3:0] NPC_NOP         = 4'hF;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_EXEC  = 2'd1,
        FS_HALT  = 2'd2
    } fstate_e;

    function automatic logic [31:0] br_off(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_npc_unit_npc_calc.sv
// Combinational next-PC selection: branch compare and target mux.
// Only the low 26 instruction bits matter here, so only those come in.
module npc_calc
    import fetch_npc_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr,
    input  logic [3:0]  NPCOp,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] npc
);

    logic [31:0] btgt;
    logic        taken;
    logic        rs_neg;
    logic        rs_zero;

    assign btgt    = pc_plus4 + br_off(instr[15:0]);
    assign rs_neg  = rs_data[31];
    assign rs_zero = (rs_data == 32'd0);

    always_comb begin
        taken = 1'b0;
        npc   = pc_plus4;
        case (NPCOp)
            NPC_JUMP:        npc   = {pc_plus4[31:28], instr, 2'b00};
            NPC_JUMPR:       npc   = rs_data;
            NPC_BRANCH_BEQ:  taken = (rs_data == rt_data);
            NPC_BRANCH_BNE:  taken = (rs_data != rt_data);
            NPC_BRANCH_BLEZ: taken = rs_neg | rs_zero;
            NPC_BRANCH_BGTZ: taken = ~rs_neg & ~rs_zero;
            NPC_BRANCH_BLTZ: taken = rs_neg;
            NPC_BRANCH_BGEZ: taken = ~rs_neg;
            default:         npc   = pc_plus4;
        endcase
        if (taken) begin
            npc = btgt;
        end
    end

endmodule

// File: rtl/fetch_npc_unit.sv
// Fetch stage: owns the PC, issues one imem read per instruction,
// presents it for one execute cycle and loads the next PC.
module fetch_npc_unit
    import fetch_npc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [3:0]  NPCOp,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        halted,
    output logic        fault
);

    localparam int CW = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

    fstate_e       state_q;
    logic [31:0]   pc_q;
    logic [31:0]   instr_q;
    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          valid_q;
    logic          halted_q;
    logic          fault_q;
    logic [31:0]   npc;

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;

    npc_calc u_npc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q[25:0]),
        .NPCOp    (NPCOp),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .npc      (npc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FS_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                FS_FETCH: begin
                    // First cycle out of reset only raises the request.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ready) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= FS_EXEC;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q    <= 1'b0;
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= FS_HALT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FS_EXEC: begin
                    valid_q <= 1'b0;
                    if (NPCOp == NPC_NOP) begin
                        halted_q <= 1'b1;
                        state_q  <= FS_HALT;
                    end else if (npc[1:0] != 2'b00) begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= FS_HALT;
                    end else begin
                        pc_q    <= npc;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        state_q <= FS_FETCH;
                    end
                end
                FS_HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    req_q    <= 1'b0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                    state_q  <= FS_HALT;
                end
            endcase
        end
    end

endmodule
